// File: rtl/branch_predict_resolve_pkg.sv
// Shared pipeline definitions: NPC-type and next-PC select codes
// used by the control unit, PC-select mux and branch resolver.
package branch_predict_resolve_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_RSVD   = 2'b11
  } npc_type_e;

  typedef enum logic [1:0] {
    NXT_PLUS4   = 2'b00,
    NXT_RECOVER = 2'b01,
    NXT_JUMP    = 2'b10,
    NXT_BRANCH  = 2'b11
  } next_type_e;

  // Only a wrong branch guess or a jump redirects fetch.
  function automatic next_type_e resolve_next(
    input logic       valid,
    input logic [1:0] npc,
    input logic       zero,
    input logic       pred
  );
    logic br;
    next_type_e r;
    br = valid && (npc == NPC_BRANCH);
    r  = NXT_PLUS4;
    unique case (1'b1)
      (br && (pred != zero) && zero):  r = NXT_BRANCH;
      (br && (pred != zero) && !zero): r = NXT_RECOVER;
      (valid && (npc == NPC_JUMP)):    r = NXT_JUMP;
      default:                         r = NXT_PLUS4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Predict/resolve bundle between the IF/EX pipeline
// and the branch history table.
interface branch_predict_resolve_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
);

  logic [PC_W-1:0]   pd_pc;
  logic              pd_taken;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [1:0]        ex_npc_type;
  logic              ex_zero;
  logic              ex_pred_taken;
  logic [1:0]        next_type;
  logic              flush;
  logic              stats_clr;
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] mis_cnt;

  modport master (
    output pd_pc, ex_valid, ex_pc,
    output ex_npc_type, ex_zero,
    output ex_pred_taken, stats_clr,
    input  pd_taken, next_type, flush,
    input  br_cnt, mis_cnt
  );

  modport slave (
    input  pd_pc, ex_valid, ex_pc,
    input  ex_npc_type, ex_zero,
    input  ex_pred_taken, stats_clr,
    output pd_taken, next_type, flush,
    output br_cnt, mis_cnt
  );

endinterface

// File: rtl/branch_predict_resolve_sat_counter.sv
// Saturating up/down counter for one branch history entry;
// exposes its next value so the predictor can bypass it.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] init,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] nxt
);

  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    nxt = cnt_q;
    if (inc && (cnt_q != '1))
      nxt = cnt_q + 1'b1;
    else if (dec && (cnt_q != '0))
      nxt = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= init;
    else     cnt_q <= nxt;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor with EX-stage resolution,
// fetch redirect select and prediction statistics.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 2,
  parameter int STAT_W    = 16
) (
  input logic clk,
  input logic rst,
  branch_predict_resolve_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] INIT =
    CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [IDX_W-1:0]  pd_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic              is_br;
  logic              upd;
  logic              mispredict;
  logic [1:0]        nt;
  logic [CNT_W-1:0]  cnt [BHT_DEPTH];
  logic [CNT_W-1:0]  nxt [BHT_DEPTH];
  logic [STAT_W-1:0] br_q;
  logic [STAT_W-1:0] mis_q;
  logic              unused;

  assign pd_idx = bus.pd_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];

  assign is_br = bus.ex_valid &&
                 (bus.ex_npc_type == NPC_BRANCH);
  assign upd   = is_br && !rst;
  assign mispredict = upd &&
    (bus.ex_pred_taken != bus.ex_zero);

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    logic hit;
    assign hit = upd && (ex_idx == IDX_W'(i));
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (hit && bus.ex_zero),
      .dec  (hit && !bus.ex_zero),
      .init (INIT),
      .cnt  (cnt[i]),
      .nxt  (nxt[i])
    );
  end

  // Same-cycle update of the fetched entry is forwarded.
  assign bus.pd_taken =
    (upd && (pd_idx == ex_idx)) ?
    nxt[ex_idx][CNT_W-1] : cnt[pd_idx][CNT_W-1];

  assign nt = rst ? NXT_PLUS4 :
    resolve_next(bus.ex_valid, bus.ex_npc_type,
                 bus.ex_zero, bus.ex_pred_taken);

  assign bus.next_type = nt;
  assign bus.flush     = (nt != NXT_PLUS4);

  always_ff @(posedge clk) begin
    if (rst || bus.stats_clr) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (upd) begin
      if (br_q != '1)
        br_q <= br_q + 1'b1;
      if (mispredict && (mis_q != '1))
        mis_q <= mis_q + 1'b1;
    end
  end

  assign bus.br_cnt  = br_q;
  assign bus.mis_cnt = mis_q;

  assign unused = ^{bus.pd_pc[1:0], bus.ex_pc[1:0],
                    bus.pd_pc[PC_W-1:IDX_W+2],
                    bus.ex_pc[PC_W-1:IDX_W+2]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed scenarios plus
// random traffic against a table-of-integers reference model.
module tb_branch_predict_resolve;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predict_resolve_if #(.PC_W(32), .STAT_W(16)) bus ();
  branch_predict_resolve_if #(.PC_W(32), .STAT_W(4))  bus4 ();

  branch_predict_resolve dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_predict_resolve #(.STAT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  int checks = 0;
  int errors = 0;

  int tbl [16];
  int m_br;
  int m_mis;
  logic [1:0] exp_nt;
  logic       exp_pt;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic int bump(input int v, input logic up);
    if (up) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic logic is_branch();
    return bus.ex_valid && (bus.ex_npc_type == 2'd1);
  endfunction

  // Expected combinational outputs for the inputs now applied.
  function automatic void predict();
    int t;
    exp_nt = 2'd0;
    if (!rst && is_branch() &&
        (bus.ex_pred_taken != bus.ex_zero))
      exp_nt = bus.ex_zero ? 2'd3 : 2'd1;
    if (!rst && bus.ex_valid && bus.ex_npc_type == 2'd2)
      exp_nt = 2'd2;
    t = tbl[idx(bus.pd_pc)];
    if (!rst && is_branch() &&
        idx(bus.pd_pc) == idx(bus.ex_pc))
      t = bump(t, bus.ex_zero);
    exp_pt = (t >= 2);
  endfunction

  task automatic drive(
    input logic        v,
    input logic [31:0] pc,
    input logic [1:0]  t,
    input logic        z,
    input logic        p,
    input logic [31:0] pdpc,
    input logic        clr
  );
    @(negedge clk);
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_npc_type   = t;
    bus.ex_zero       = z;
    bus.ex_pred_taken = p;
    bus.pd_pc         = pdpc;
    bus.stats_clr     = clr;
    #1;
    predict();
  endtask

  // Advance the model across one rising edge.
  task automatic tick();
    logic br;
    logic mis;
    @(posedge clk);
    br  = is_branch();
    mis = br && (bus.ex_pred_taken != bus.ex_zero);
    if (rst) begin
      for (int i = 0; i < 16; i++) tbl[i] = 1;
      m_br  = 0;
      m_mis = 0;
    end else begin
      if (bus.stats_clr) begin
        m_br  = 0;
        m_mis = 0;
      end else if (br) begin
        if (m_br < 65535) m_br++;
        if (mis && m_mis < 65535) m_mis++;
      end
      if (br)
        tbl[idx(bus.ex_pc)] = bump(tbl[idx(bus.ex_pc)],
                                   bus.ex_zero);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h40, 2'd1, 1, 0, 32'h40, 0);
    checks++;
    if (bus.next_type !== 2'd0 || bus.flush !== 1'b0) begin
      errors++;
      $display("FAIL rst_redirect got nt=%0d fl=%0b exp 0/0",
               bus.next_type, bus.flush);
    end
    tick();
    drive(1, 32'h40, 2'd1, 1, 0, 32'h40, 1);
    tick();
    checks++;
    if (bus.br_cnt !== 16'd0 || bus.mis_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_stats got br=%0d mis=%0d exp 0/0",
               bus.br_cnt, bus.mis_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 2'd0, 0, 0, 32'(i * 4), 0);
      checks++;
      if (bus.pd_taken !== 1'b0) begin
        errors++;
        $display("FAIL rst_entry %0d got %0b exp 0",
                 i, bus.pd_taken);
      end
      tick();
    end
  endtask

  task automatic test_first_branch();
    drive(0, 0, 2'd0, 0, 0, 32'h40, 0);
    checks++;
    if (bus.pd_taken !== 1'b0) begin
      errors++;
      $display("FAIL init_pred got %0b exp 0", bus.pd_taken);
    end
    tick();
    drive(1, 32'h40, 2'd1, 1, 0, 32'h44, 0);
    checks++;
    if (bus.next_type !== 2'd3 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL taken_mis got nt=%0d fl=%0b exp 3/1",
               bus.next_type, bus.flush);
    end
    tick();
    drive(0, 0, 2'd0, 0, 0, 32'h40, 0);
    checks++;
    if (bus.pd_taken !== 1'b1) begin
      errors++;
      $display("FAIL trained_pred got %0b exp 1", bus.pd_taken);
    end
    tick();
  endtask

  task automatic test_saturate();
    int mis0;
    logic z;
    mis0 = m_mis;
    for (int i = 0; i < 12; i++) begin
      z = (i < 4);
      drive(1, 32'h40, 2'd1, z, tbl[0] >= 2, 32'h40, 0);
      checks++;
      if (bus.next_type !== exp_nt || bus.flush !== (exp_nt != 0)
          || bus.pd_taken !== exp_pt) begin
        errors++;
        $display("FAIL sat_step %0d got nt=%0d fl=%0b pt=%0b exp %0d/%0b",
                 i, bus.next_type, bus.flush, bus.pd_taken,
                 exp_nt, exp_pt);
      end
      tick();
    end
    checks++;
    if (int'(bus.mis_cnt) - mis0 !== 2) begin
      errors++;
      $display("FAIL sat_mis got %0d exp 2",
               int'(bus.mis_cnt) - mis0);
    end
    drive(0, 0, 2'd0, 0, 0, 32'h40, 0);
    checks++;
    if (bus.pd_taken !== 1'b0 || bus.br_cnt !== 16'(m_br)) begin
      errors++;
      $display("FAIL sat_end got pt=%0b br=%0d exp 0/%0d",
               bus.pd_taken, bus.br_cnt, m_br);
    end
    tick();
  endtask

  task automatic test_jump();
    drive(1, 32'h40, 2'd2, 1, 1, 32'h40, 0);
    checks++;
    if (bus.next_type !== 2'd2 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL jump got nt=%0d fl=%0b exp 2/1",
               bus.next_type, bus.flush);
    end
    tick();
    drive(0, 32'h40, 2'd2, 1, 1, 32'h40, 0);
    checks++;
    if (bus.next_type !== 2'd0 || bus.flush !== 1'b0 ||
        bus.pd_taken !== 1'b0 || bus.br_cnt !== 16'(m_br)) begin
      errors++;
      $display("FAIL jump_idle got nt=%0d fl=%0b pt=%0b br=%0d exp 0/0/0/%0d",
               bus.next_type, bus.flush, bus.pd_taken,
               bus.br_cnt, m_br);
    end
    tick();
  endtask

  task automatic test_bypass();
    rst = 1'b1;
    drive(0, 0, 2'd0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(1, 32'h80, 2'd1, 1, 0, 32'h80, 0);
    checks++;
    if (bus.pd_taken !== 1'b1 || bus.next_type !== 2'd3) begin
      errors++;
      $display("FAIL bypass got pt=%0b nt=%0d exp 1/3",
               bus.pd_taken, bus.next_type);
    end
    tick();
  endtask

  task automatic test_stats_clr();
    drive(1, 32'h10, 2'd1, 0, 1, 32'h0, 0);
    tick();
    drive(1, 32'h10, 2'd1, 0, 1, 32'h0, 1);
    checks++;
    if (bus.next_type !== 2'd1) begin
      errors++;
      $display("FAIL recover got %0d exp 1", bus.next_type);
    end
    tick();
    checks++;
    if (bus.br_cnt !== 16'd0 || bus.mis_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr got br=%0d mis=%0d exp 0/0",
               bus.br_cnt, bus.mis_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] pd;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      pc  = 32'($urandom_range(0, 63)) << 2;
      pd  = ($urandom_range(0, 3) == 0) ? pc :
            32'($urandom_range(0, 63)) << 2;
      drive($urandom_range(0, 3) != 0, pc,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), pd,
            $urandom_range(0, 31) == 0);
      checks++;
      if (bus.next_type !== exp_nt || bus.flush !== (exp_nt != 0)
          || bus.pd_taken !== exp_pt) begin
        errors++;
        $display("FAIL rand_comb %0d got nt=%0d fl=%0b pt=%0b exp %0d/%0b",
                 n, bus.next_type, bus.flush, bus.pd_taken,
                 exp_nt, exp_pt);
      end
      tick();
      checks++;
      if (bus.br_cnt !== 16'(m_br) ||
          bus.mis_cnt !== 16'(m_mis)) begin
        errors++;
        $display("FAIL rand_stats %0d got %0d/%0d exp %0d/%0d",
                 n, bus.br_cnt, bus.mis_cnt, m_br, m_mis);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stat4();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus4.ex_valid      = 1'b1;
      bus4.ex_npc_type   = 2'd1;
      bus4.ex_pc         = 32'(i * 4);
      bus4.ex_zero       = 1'b1;
      bus4.ex_pred_taken = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus4.ex_valid = 1'b0;
    checks++;
    if (bus4.br_cnt !== 4'd15 || bus4.mis_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stat4_sat got br=%0d mis=%0d exp 15/15",
               bus4.br_cnt, bus4.mis_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 16; i++) tbl[i] = 1;
    m_br  = 0;
    m_mis = 0;
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_npc_type    = 2'd0;
    bus.ex_zero        = 1'b0;
    bus.ex_pred_taken  = 1'b0;
    bus.pd_pc          = '0;
    bus.stats_clr      = 1'b0;
    bus4.ex_valid      = 1'b0;
    bus4.ex_pc         = '0;
    bus4.ex_npc_type   = 2'd0;
    bus4.ex_zero       = 1'b0;
    bus4.ex_pred_taken = 1'b0;
    bus4.pd_pc         = '0;
    bus4.stats_clr     = 1'b0;
    test_reset();
    test_first_branch();
    test_saturate();
    test_jump();
    test_bypass();
    test_stats_clr();
    test_random();
    test_stat4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
